// File: rtl/hs_ob_sched.sv
// rtl/hs_ob_sched.sv - outband ring scheduler: fetch descriptors, dispatch to four port channels
`timescale 1ns/1ps
module hs_ob_sched #(
  parameter int C_RING_ENTRIES = 256,
  parameter int C_ENTRY_SHIFT  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ring_enable,
  input  logic [31:0] outband_base,
  input  logic [11:0] outband_prod_index,
  output logic [11:0] outband_cons_index,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic [3:0]  cmd_valid,
  output logic [31:0] cmd_data,
  input  logic [3:0]  cmd_ready,
  output logic        busy,
  output logic [31:0] disp_count
);

  // Index mask also keeps the unused upper consumer bits at zero.
  localparam logic [11:0] MASK = 12'(C_RING_ENTRIES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISP} state_t;

  state_t      state_q, state_d;
  logic [11:0] cons_q, cons_d;
  logic        rd_req_q, rd_req_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [3:0]  cmd_valid_q, cmd_valid_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic [1:0]  port_q, port_d;
  logic        busy_q, busy_d;
  logic [31:0] disp_q, disp_d;

  logic        ring_empty;
  logic [31:0] fetch_addr;

  assign ring_empty = ((outband_prod_index & MASK) == cons_q);
  assign fetch_addr = outband_base + ({20'd0, cons_q} << C_ENTRY_SHIFT);

  // Next-state and registered-output computation for the fetch/dispatch sequence.
  always_comb begin
    state_d     = state_q;
    cons_d      = cons_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    port_d      = port_q;
    disp_d      = disp_q;
    case (state_q)
      S_IDLE: begin
        // Base is sampled only here, so a mid-transaction base change waits for the next entry.
        if (ring_enable && !ring_empty) begin
          rd_addr_d = fetch_addr;
          rd_req_d  = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_valid) begin
          cmd_data_d  = rd_data;
          port_d      = rd_data[1:0];
          cmd_valid_d = 4'b0001 << rd_data[1:0];
          state_d     = S_DISP;
        end
      end
      S_DISP: begin
        // Only the addressed port's ready matters; the others are don't-care.
        if (cmd_ready[port_q]) begin
          cmd_valid_d = 4'b0000;
          cons_d      = (cons_q + 12'd1) & MASK;
          disp_d      = disp_q + 32'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cons_q      <= 12'd0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= 32'd0;
      cmd_valid_q <= 4'b0000;
      cmd_data_q  <= 32'd0;
      port_q      <= 2'd0;
      busy_q      <= 1'b0;
      disp_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      cons_q      <= cons_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      port_q      <= port_d;
      busy_q      <= busy_d;
      disp_q      <= disp_d;
    end
  end

  assign outband_cons_index = cons_q;
  assign rd_req             = rd_req_q;
  assign rd_addr            = rd_addr_q;
  assign cmd_valid          = cmd_valid_q;
  assign cmd_data           = cmd_data_q;
  assign busy               = busy_q;
  assign disp_count         = disp_q;

endmodule

// File: tb/tb_hs_ob_sched.sv
// tb/tb_hs_ob_sched.sv - scoreboard bench for hs_ob_sched with a 4-entry ring
`timescale 1ns/1ps
module tb_hs_ob_sched;

  logic        clk;
  logic        rst;
  logic        ring_enable;
  logic [31:0] base;
  logic [11:0] prod;
  logic [11:0] cons;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  cmd_valid;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_ready;
  logic        busy;
  logic [31:0] disp_count;

  int checks;
  int failures;
  int exp_cons;
  int exp_disp;
  logic [31:0] exp_q[$];

  hs_ob_sched #(.C_RING_ENTRIES(4), .C_ENTRY_SHIFT(4)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .ring_enable(ring_enable),
    .outband_base(base),
    .outband_prod_index(prod),
    .outband_cons_index(cons),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .busy(busy),
    .disp_count(disp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for a read request, hand the descriptor back and queue what the port should see.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                          input bit drop_en, output int req_wait);
    int i;
    for (i = 0; i < 50; i++) begin
      if (rd_req === 1'b1) break;
      @(negedge clk);
    end
    req_wait = i;
    checks++;
    if (i == 50) begin
      failures++;
      $display("FAIL fetch_timeout rd_req never rose, required 1 within 50 cycles");
      return;
    end
    checks++;
    if (rd_addr !== exp_addr) begin
      failures++;
      $display("FAIL rd_addr got=%h exp=%h", rd_addr, exp_addr);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_req got=%b exp=1", busy);
    end
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    checks++;
    if (rd_req !== 1'b0) begin
      failures++;
      $display("FAIL rd_req_drop got=%b exp=0", rd_req);
    end
    if (drop_en) ring_enable = 1'b0;
    rd_valid = 1'b1;
    rd_data  = data;
    exp_q.push_back(data);
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data  = $urandom;
  endtask

  // Check the dispatched command against the scoreboard, apply backpressure, then handshake.
  task automatic do_dispatch(input int ready_delay);
    logic [31:0] exp;
    logic [3:0]  exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=0 entries exp>=1");
      return;
    end
    exp   = exp_q.pop_front();
    exp_v = 4'b0001 << exp[1:0];
    checks++;
    if (cmd_valid !== exp_v || cmd_data !== exp) begin
      failures++;
      $display("FAIL cmd got_v=%b got_d=%h exp_v=%b exp_d=%h", cmd_valid, cmd_data, exp_v, exp);
    end
    for (int k = 0; k < ready_delay; k++) begin
      cmd_ready = ~exp_v;
      @(negedge clk);
      checks++;
      if (cmd_valid !== exp_v || cmd_data !== exp || cons !== 12'(exp_cons) || rd_req !== 1'b0) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got_v=%b cons=%0d req=%b exp_v=%b cons=%0d req=0",
                 k, cmd_valid, cons, rd_req, exp_v, exp_cons);
      end
    end
    cmd_ready = exp_v;
    @(negedge clk);
    cmd_ready = 4'b0000;
    exp_cons = (exp_cons + 1) % 4;
    exp_disp++;
    checks++;
    if (cons !== 12'(exp_cons) || disp_count !== 32'(exp_disp) || cmd_valid !== 4'b0000) begin
      failures++;
      $display("FAIL handshake got cons=%0d disp=%0d v=%b exp cons=%0d disp=%0d v=0000",
               cons, disp_count, cmd_valid, exp_cons, exp_disp);
    end
  endtask

  task automatic check_idle(input int cycles, input string name);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      checks++;
      if (rd_req !== 1'b0 || busy !== 1'b0 || cons !== 12'(exp_cons)) begin
        failures++;
        $display("FAIL %s cyc=%0d got req=%b busy=%b cons=%0d exp req=0 busy=0 cons=%0d",
                 name, k, rd_req, busy, cons, exp_cons);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prod = 12'd0;
    ring_enable = 1'b1;
    exp_cons = 0;
    exp_disp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (cons !== 12'd0 || rd_req !== 1'b0 || rd_addr !== 32'd0 || cmd_valid !== 4'd0 ||
          cmd_data !== 32'd0 || busy !== 1'b0 || disp_count !== 32'd0) begin
        failures++;
        $display("FAIL reset_values cyc=%0d cons=%0d req=%b addr=%h v=%b d=%h busy=%b disp=%0d exp all 0",
                 k, cons, rd_req, rd_addr, cmd_valid, cmd_data, busy, disp_count);
      end
    end
  endtask

  task automatic test_single();
    int w;
    base = 32'h1000_0000;
    prod = 12'd1;
    do_fetch(32'h1000_0000, 32'h0000_0ABE, 1'b0, w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=1", w);
    end
    do_dispatch(0);
    check_idle(3, "single_idle");
  endtask

  task automatic test_backpressure();
    int w;
    prod = 12'd2;
    do_fetch(32'h1000_0010, 32'h1234_5671, 1'b0, w);
    do_dispatch(10);
  endtask

  task automatic test_wrap();
    int w;
    prod = 12'd3;
    do_fetch(32'h1000_0020, 32'h0000_0103, 1'b0, w);
    do_dispatch(0);
    // Upper producer bits must be ignored: 5 masks to 1.
    prod = 12'd5;
    do_fetch(32'h1000_0030, 32'hCAFE_0000, 1'b0, w);
    do_dispatch(0);
    do_fetch(32'h1000_0000, 32'h0BAD_F00D, 1'b0, w);
    do_dispatch(0);
    check_idle(10, "wrap_idle");
  endtask

  task automatic test_disable();
    int w;
    prod = 12'd4;
    do_fetch(32'h1000_0010, 32'h0000_0552, 1'b1, w);
    do_dispatch(0);
    check_idle(10, "disable_idle");
    ring_enable = 1'b1;
    do_fetch(32'h1000_0020, 32'h0000_0661, 1'b0, w);
    do_dispatch(0);
    do_fetch(32'h1000_0030, 32'h0000_0770, 1'b0, w);
    do_dispatch(2);
  endtask

  task automatic test_reset_mid();
    int w;
    prod = 12'd2;
    do_fetch(32'h1000_0000, 32'h0000_0881, 1'b0, w);
    do_dispatch(0);
    do_fetch(32'h1000_0010, 32'hDEAD_BEE3, 1'b0, w);
    checks++;
    if (cmd_valid !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_disp got=%b exp=1000", cmd_valid);
    end
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cons = 0;
    exp_disp = 0;
    checks++;
    if (cmd_valid !== 4'd0 || cons !== 12'd0 || disp_count !== 32'd0 || busy !== 1'b0 || rd_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear v=%b cons=%0d disp=%0d busy=%b req=%b exp all 0",
               cmd_valid, cons, disp_count, busy, rd_req);
    end
    rd_valid = 1'b1;
    rd_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    rd_valid = 1'b0;
    checks++;
    if (cmd_valid !== 4'd0) begin
      failures++;
      $display("FAIL rstmid_stray got=%b exp=0000", cmd_valid);
    end
    do_fetch(32'h1000_0000, 32'h0000_0040, 1'b0, w);
    do_dispatch(0);
    do_fetch(32'h1000_0010, 32'h0000_0991, 1'b0, w);
    do_dispatch(0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    ring_enable = 1'b0;
    base        = 32'd0;
    prod        = 12'd0;
    rd_ack      = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = 32'd0;
    cmd_ready   = 4'd0;
    exp_cons    = 0;
    exp_disp    = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
